pipe_seq_ctrl: RTL

Pipeline sequencing controller for the five-stage processor. It takes the raw hazard indications from decode (load-use, POP data hazard) and the branch-taken signal from execute, and produces the per-stage enable and flush controls for PC, IF/ID and ID/EX. It also runs the multi-cycle interrupt entry sequence: drain the pipeline, push PC, push flags, then load the vector.

---
 rtl/pipe_seq_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl
//   Pipeline sequencing controller for the five-stage processor. Turns the
//   decode hazards (load-use, POP) and the execute branch-taken signal into
//   per-stage enable/flush controls. It also runs the interrupt entry
//   sequence: drain fetch, push PC, push flags, then load the vector.
//
//   Optional feature macro: PIPE_SEQ_CTRL_IRQ_EN
//     defined   : interrupt edge detect, pending flag and IRQ_* states present
//     undefined : irq ignored, irq_* outputs tied 0, busy only in POP_STALL
//
// Parameters
//   POP_STALL_CYC  total bubble cycles for a POP hazard (1..7)
//   DRAIN_CYC      fetch-bubble cycles before the interrupt pushes (1..7)
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   lu_hazard       load-use hazard from decode
//   pop_hazard      POP data hazard from decode
//   branch_taken    branch/jump resolved taken in execute
//   irq             external interrupt request (rising edge significant)
//   pc_en           PC write enable
//   if_id_en        IF/ID write enable
//   if_id_flush     load NOP into IF/ID
//   id_ex_flush     load bubble into ID/EX
//   irq_push_pc     memory stage pushes return PC
//   irq_push_flags  memory stage pushes CCR
//   irq_vec_load    PC loads the interrupt vector
//   irq_ack         one-cycle pulse when interrupt entry completes
//   busy            controller is not in RUN

module pipe_seq_ctrl #(
  parameter int POP_STALL_CYC = 2,
  parameter int DRAIN_CYC     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lu_hazard,
  input  logic pop_hazard,
  input  logic branch_taken,
  input  logic irq,
  output logic pc_en,
  output logic if_id_en,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic irq_push_pc,
  output logic irq_push_flags,
  output logic irq_vec_load,
  output logic irq_ack,
  output logic busy
);

`ifdef PIPE_SEQ_CTRL_IRQ_EN
  typedef enum logic [2:0] {
    RUN          = 3'd0,
    POP_STALL    = 3'd1,
    IRQ_DRAIN    = 3'd2,
    IRQ_PUSH_PC  = 3'd3,
    IRQ_PUSH_FLG = 3'd4,
    IRQ_VEC      = 3'd5
  } state_t;
`else
  typedef enum logic [0:0] {
    RUN       = 1'b0,
    POP_STALL = 1'b1
  } state_t;
`endif

  // The first POP stall cycle is spent in RUN, so the counter covers the rest.
  localparam logic [2:0] POP_CNT_INIT   = 3'(POP_STALL_CYC - 2);
  localparam logic [2:0] DRAIN_CNT_INIT = 3'(DRAIN_CYC - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       irq_start;

`ifdef PIPE_SEQ_CTRL_IRQ_EN
  logic irq_d;
  logic irq_pend;
  logic irq_edge;

  assign irq_edge  = irq & ~irq_d;
  // The edge itself may start entry so the first drain cycle directly
  // follows the edge cycle when RUN is free; otherwise the pending flag
  // holds the request until RUN is free.
  assign irq_start = irq_pend | irq_edge;
`else
  logic irq_unused;

  assign irq_unused = irq;
  assign irq_start  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (branch_taken) begin
          state_nxt = RUN;
        end else if (pop_hazard) begin
          if (POP_STALL_CYC > 1) begin
            state_nxt = POP_STALL;
            cnt_nxt   = POP_CNT_INIT;
          end
        end else if (lu_hazard) begin
          state_nxt = RUN;
        end else if (irq_start) begin
`ifdef PIPE_SEQ_CTRL_IRQ_EN
          state_nxt = IRQ_DRAIN;
          cnt_nxt   = DRAIN_CNT_INIT;
`endif
        end
      end
      POP_STALL: begin
        if (branch_taken || cnt == 3'd0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
`ifdef PIPE_SEQ_CTRL_IRQ_EN
      IRQ_DRAIN: begin
        if (cnt == 3'd0) begin
          state_nxt = IRQ_PUSH_PC;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      IRQ_PUSH_PC:  state_nxt = IRQ_PUSH_FLG;
      IRQ_PUSH_FLG: state_nxt = IRQ_VEC;
      IRQ_VEC:      state_nxt = RUN;
`endif
      default:      state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef PIPE_SEQ_CTRL_IRQ_EN
  // Clear wins over a coincident edge; edges during the sequence are lost
  // because the flag is already set until IRQ_VEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_d    <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      irq_d <= irq;
      if (state == IRQ_VEC) begin
        irq_pend <= 1'b0;
      end else if (irq_edge) begin
        irq_pend <= 1'b1;
      end
    end
  end
`endif

  always_comb begin
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    irq_push_pc    = 1'b0;
    irq_push_flags = 1'b0;
    irq_vec_load   = 1'b0;
    irq_ack        = 1'b0;
    busy           = (state != RUN);
    case (state)
      RUN, POP_STALL: begin
        if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (state == POP_STALL || pop_hazard || lu_hazard) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
`ifdef PIPE_SEQ_CTRL_IRQ_EN
      IRQ_DRAIN: begin
        // A late branch still updates PC so its target is what gets pushed.
        pc_en       = branch_taken;
        if_id_flush = 1'b1;
        id_ex_flush = branch_taken;
      end
      IRQ_PUSH_PC: begin
        irq_push_pc = 1'b1;
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      IRQ_PUSH_FLG: begin
        irq_push_flags = 1'b1;
        pc_en          = 1'b0;
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
      end
      IRQ_VEC: begin
        irq_vec_load = 1'b1;
        if_id_flush  = 1'b1;
        irq_ack      = 1'b1;
      end
`endif
      default: begin
        pc_en = 1'b1;
      end
    endcase
    if (!rst_n) begin
      pc_en          = 1'b0;
      if_id_en       = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      irq_push_pc    = 1'b0;
      irq_push_flags = 1'b0;
      irq_vec_load   = 1'b0;
      irq_ack        = 1'b0;
      busy           = 1'b0;
    end
  end

endmodule
